// File: rtl/bt_alert_scheduler_pkg.sv
// Shared encodings, ASCII constants and helpers for the Bluetooth alert message path.
// BT_ALERT_CHECKSUM_EN selects the 8-byte message with a hex XOR checksum.
package bt_alert_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_SEND = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    localparam logic [7:0] ASCII_E     = 8'h45;
    localparam logic [7:0] ASCII_V     = 8'h56;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;

`ifdef BT_ALERT_CHECKSUM_EN
    localparam int MSG_LEN = 8;
`else
    localparam int MSG_LEN = 6;
`endif

    localparam int ID_W  = 4;
    localparam int IDX_W = 3;

    // Uppercase hex digit: 0-9 -> '0'..'9', 10-15 -> 'A'..'F' ('A' - 10 = 0x37).
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return ASCII_ZERO + {4'h0, nib};
        end
        return 8'h37 + {4'h0, nib};
    endfunction

endpackage

// File: rtl/bt_alert_scheduler_if.sv
// Byte stream from the alert scheduler to the HM-10 UART transmitter, plus message status.
interface bt_alert_scheduler_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       msg_done;
    logic [3:0] cur_evt;

    modport master (
        output tx_data,
        output tx_valid,
        output msg_done,
        output cur_evt,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        input  msg_done,
        input  cur_evt,
        output tx_ready
    );
endinterface

// File: rtl/bt_alert_scheduler_rr_arbiter.sv
// Round-robin pick of the first request at or after the pointer, wrapping; purely combinational.
module bt_rr_arbiter
    import bt_alert_scheduler_pkg::*;
#(
    parameter int NUM_EVT = 4
) (
    input  logic [NUM_EVT-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_EVT-1:0] o_grant,
    output logic [ID_W-1:0]    o_id,
    output logic               o_any
);

    // Scan from farthest to nearest so the nearest request overwrites any earlier pick.
    always_comb begin
        int j;
        j       = 0;
        o_grant = '0;
        o_id    = '0;
        o_any   = |i_req;
        for (int k = NUM_EVT - 1; k >= 0; k--) begin
            j = int'(i_ptr) + k;
            if (j >= NUM_EVT) begin
                j = j - NUM_EVT;
            end
            if (i_req[j]) begin
                o_grant    = '0;
                o_grant[j] = 1'b1;
                o_id       = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/bt_alert_scheduler.sv
// Event-to-ASCII alert scheduler feeding the HM-10 UART TX over a valid/ready byte stream.
// Define BT_ALERT_CHECKSUM_EN to append two hex checksum characters before CR LF.
module bt_alert_scheduler
    import bt_alert_scheduler_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int NUM_EVT    = 4,
    parameter int GAP_CYCLES = 500_000
) (
    input  logic                 clk_50mhz,
    input  logic                 rst_n,
    input  logic [NUM_EVT-1:0]   evt_in,
    bt_alert_scheduler_if.master tx_if,
    output logic                 busy,
    output logic [NUM_EVT-1:0]   overflow,
    input  logic                 clr_overflow
);

    // GAP_CYCLES is meant to be derived from CLOCK_FREQ; a non-positive clock adds a guard bit.
    localparam int GAP_W = $clog2(GAP_CYCLES + 1) + ((CLOCK_FREQ > 0) ? 0 : 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [NUM_EVT-1:0] r_sync1;
    logic [NUM_EVT-1:0] r_sync2;
    logic [NUM_EVT-1:0] r_sync3;
    logic [NUM_EVT-1:0] r_pending;
    logic [NUM_EVT-1:0] r_overflow;
    logic [GAP_W-1:0]   r_gap;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [ID_W-1:0]    r_cur_evt;
    logic [IDX_W-1:0]   r_idx;

    logic [NUM_EVT-1:0] w_rise;
    logic [NUM_EVT-1:0] w_grant;
    logic [NUM_EVT-1:0] w_clr_mask;
    logic [NUM_EVT-1:0] w_ovf_set;
    logic [ID_W-1:0]    w_grant_id;
    logic               w_any;
    logic               w_xfer;
    logic               w_last;
    logic [7:0]         w_digit;
    logic [7:0]         w_byte;
`ifdef BT_ALERT_CHECKSUM_EN
    logic [7:0]         w_csum;
`endif

    bt_rr_arbiter #(
        .NUM_EVT (NUM_EVT)
    ) u_arb (
        .i_req   (r_pending),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_id    (w_grant_id),
        .o_any   (w_any)
    );

    assign w_rise     = r_sync2 & ~r_sync3;
    assign w_clr_mask = (r_state == ST_ARB) ? w_grant : '0;
    // A rise on an id being granted this cycle re-queues it instead of counting as overflow.
    assign w_ovf_set  = w_rise & r_pending & ~w_clr_mask;
    assign w_xfer     = (r_state == ST_SEND) && tx_if.tx_ready;
    assign w_last     = (r_idx == IDX_W'(MSG_LEN - 1));

    always_comb begin
        w_digit = ASCII_ZERO + {4'h0, r_cur_evt};
`ifdef BT_ALERT_CHECKSUM_EN
        w_csum  = ASCII_E ^ ASCII_V ^ ASCII_COLON ^ w_digit;
`endif
        w_byte  = '0;
        case (r_idx)
            3'd0: w_byte = ASCII_E;
            3'd1: w_byte = ASCII_V;
            3'd2: w_byte = ASCII_COLON;
            3'd3: w_byte = w_digit;
`ifdef BT_ALERT_CHECKSUM_EN
            3'd4: w_byte = hex_ascii(w_csum[7:4]);
            3'd5: w_byte = hex_ascii(w_csum[3:0]);
            3'd6: w_byte = ASCII_CR;
            3'd7: w_byte = ASCII_LF;
`else
            3'd4: w_byte = ASCII_CR;
            3'd5: w_byte = ASCII_LF;
`endif
            default: w_byte = '0;
        endcase
    end

    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: if (w_any && (r_gap == '0)) w_state_nxt = ST_ARB;
            ST_ARB:  w_state_nxt = ST_SEND;
            ST_SEND: if (w_xfer && w_last) w_state_nxt = ST_GAP;
            ST_GAP:  if (r_gap <= GAP_W'(1)) w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_sync3    <= '0;
            r_pending  <= '0;
            r_overflow <= '0;
            r_gap      <= '0;
            r_rr_ptr   <= '0;
            r_cur_evt  <= '0;
            r_idx      <= '0;
        end else begin
            r_sync1    <= evt_in;
            r_sync2    <= r_sync1;
            r_sync3    <= r_sync2;
            r_pending  <= (r_pending & ~w_clr_mask) | w_rise;
            r_overflow <= (clr_overflow ? '0 : r_overflow) | w_ovf_set;

            if (r_state == ST_ARB) begin
                r_cur_evt <= w_grant_id;
                r_rr_ptr  <= (w_grant_id == ID_W'(NUM_EVT - 1)) ? '0 : w_grant_id + ID_W'(1);
                r_idx     <= '0;
            end else if (w_xfer) begin
                r_idx <= r_idx + IDX_W'(1);
            end

            if (w_xfer && w_last) begin
                r_gap <= GAP_W'(GAP_CYCLES);
            end else if (r_gap != '0) begin
                r_gap <= r_gap - GAP_W'(1);
            end
        end
    end

    assign tx_if.tx_valid = (r_state == ST_SEND);
    assign tx_if.tx_data  = (r_state == ST_SEND) ? w_byte : 8'h00;
    assign tx_if.msg_done = w_xfer && w_last;
    assign tx_if.cur_evt  = r_cur_evt;
    assign overflow       = r_overflow;
    assign busy           = (r_state != ST_IDLE) | (|r_pending) | (r_gap != '0);

endmodule
